hilo_md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the Execute stage and runs an iterative one-bit-per-cycle multiply or divide. It commits results to HI/LO and drives a stall to the hazard unit whenever Decode needs HI/LO or the unit while it is busy. It replaces the single-cycle mult/div results and the `GP_regs` HI/LO pair inside `TOP`.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_iter_core.sv | 71 +++++++
 rtl/hilo_md_sequencer.sv | 143 ++++++++++++++
 tb/tb_hilo_md_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package md_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam int unsigned MD_CNT_W      = $clog2(MD_DATA_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // MULT/MULTU/DIV/DIVU use the iterative core; MTHI/MTLO do not.
  function automatic logic is_iter_op(input logic [2:0] op);
    return op < OP_MTHI;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One-bit-per-cycle datapath: LSB-first shift-add multiply and MSB-first
// restoring divide on a {hi,lo} accumulator, plus the iteration counter.
module md_iter_core
  import md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  div_mode,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] acc_hi,
  output logic [DATA_WIDTH-1:0] acc_lo,
  output logic                  last
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] hi_q, lo_q, opnd_q, hi_d, lo_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  div_q;
  logic [DATA_WIDTH:0]   add_sum, rem_sh;
  logic [DATA_WIDTH-1:0] sub_diff;
  logic                  rem_ge;

  // opnd_q is the multiplicand for multiply and the divisor for divide.
  always_comb begin
    add_sum  = {1'b0, hi_q} + {1'b0, opnd_q};
    rem_sh   = {hi_q, lo_q[DATA_WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    sub_diff = rem_sh[DATA_WIDTH-1:0] - opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (div_q) begin
      hi_d = rem_ge ? sub_diff : rem_sh[DATA_WIDTH-1:0];
      lo_d = {lo_q[DATA_WIDTH-2:0], rem_ge};
    end else if (lo_q[0]) begin
      {hi_d, lo_d} = {add_sum, lo_q[DATA_WIDTH-1:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= div_mode ? op_a : op_b;
      opnd_q <= div_mode ? op_b : op_a;
      cnt_q  <= CNT_W'(DATA_WIDTH - 1);
      div_q  <= div_mode;
    end else if (step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = (cnt_q == '0);

endmodule

// File: rtl/hilo_md_sequencer.sv
// HI/LO owner for the pipeline: sequences iterative MULT/DIV, handles
// MTHI/MTLO, applies sign correction and raises the Decode stall.
module hilo_md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  startE,
  input  logic [2:0]            opE,
  input  logic [DATA_WIDTH-1:0] srcAE,
  input  logic [DATA_WIDTH-1:0] srcBE,
  input  logic                  flushE,
  input  logic                  mfReqD,
  input  logic                  mdReqD,
  output logic                  busy,
  output logic                  stallMD,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hiOut,
  output logic [DATA_WIDTH-1:0] loOut
);

  md_state_e state_q, state_d;

  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] hi_q, lo_q, a_raw_q;
  logic                  qsign_q, rsign_q, div_q, div0_q;

  logic                  accept, iter_op, signed_op, div_op, div0;
  logic                  sign_a, sign_b;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic                  core_load, core_step, core_last;
  logic [DATA_WIDTH-1:0] core_hi, core_lo, fix_hi, fix_lo;
  logic [2*DATA_WIDTH-1:0] prod;

  // Operand decode and magnitude extraction for the accepted op.
  always_comb begin
    accept    = startE & ~flushE & ~busy_q;
    iter_op   = is_iter_op(opE);
    signed_op = (opE == OP_MULT) || (opE == OP_DIV);
    div_op    = (opE == OP_DIV) || (opE == OP_DIVU);
    div0      = div_op && (srcBE == '0);
    sign_a    = signed_op & srcAE[DATA_WIDTH-1];
    sign_b    = signed_op & srcBE[DATA_WIDTH-1];
    abs_a     = sign_a ? (DATA_WIDTH'(0) - srcAE) : srcAE;
    abs_b     = sign_b ? (DATA_WIDTH'(0) - srcBE) : srcBE;
  end

  md_iter_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (core_load),
    .div_mode (div_op),
    .step     (core_step),
    .op_a     (abs_a),
    .op_b     (abs_b),
    .acc_hi   (core_hi),
    .acc_lo   (core_lo),
    .last     (core_last)
  );

  // Next state and core controls.
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && iter_op) begin
          core_load = 1'b1;
          state_d   = div0 ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign correction of the finished accumulator.
  always_comb begin
    prod   = {core_hi, core_lo};
    fix_hi = core_hi;
    fix_lo = core_lo;
    if (div0_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else if (div_q) begin
      fix_lo = qsign_q ? (DATA_WIDTH'(0) - core_lo) : core_lo;
      fix_hi = rsign_q ? (DATA_WIDTH'(0) - core_hi) : core_hi;
    end else if (qsign_q) begin
      {fix_hi, fix_lo} = (2*DATA_WIDTH)'(0) - prod;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_raw_q <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_FIX);
      if (core_load) begin
        a_raw_q <= srcAE;
        qsign_q <= sign_a ^ sign_b;
        rsign_q <= sign_a;
        div_q   <= div_op;
        div0_q  <= div0;
      end
      if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (accept && (opE == OP_MTHI)) begin
        hi_q <= srcAE;
      end else if (accept && (opE == OP_MTLO)) begin
        lo_q <= srcAE;
      end
    end
  end

  // Stall is combinational so Decode holds in the accept cycle itself.
  assign stallMD = (busy_q | (accept & iter_op)) & (mfReqD | mdReqD);
  assign busy    = busy_q;
  assign done    = done_q;
  assign hiOut   = hi_q;
  assign loOut   = lo_q;

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed bench for hilo_md_sequencer with hand-computed expectations.
module tb_hilo_md_sequencer;

  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic         startE, flushE, mfReqD, mdReqD;
  logic [2:0]   opE;
  logic [W-1:0] srcAE, srcBE;
  logic         busy, stallMD, done;
  logic [W-1:0] hiOut, loOut;

  int total  = 0;
  int passed = 0;
  int cyc;

  hilo_md_sequencer #(.DATA_WIDTH(W)) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .startE  (startE),
    .opE     (opE),
    .srcAE   (srcAE),
    .srcBE   (srcBE),
    .flushE  (flushE),
    .mfReqD  (mfReqD),
    .mdReqD  (mdReqD),
    .busy    (busy),
    .stallMD (stallMD),
    .done    (done),
    .hiOut   (hiOut),
    .loOut   (loOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starting an op while the unit is busy is a hazard-unit protocol breach.
  always @(posedge clk) begin
    if (rst_n && startE && busy) begin
      total++;
      $error("FAIL start_while_busy observed startE=1 busy=1 required no start");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issue one op in the current cycle, then count cycles until busy drops.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int ncyc);
    startE = 1'b1;
    opE    = op;
    srcAE  = a;
    srcBE  = b;
    tick();
    startE = 1'b0;
    ncyc   = 0;
    while (busy && ncyc < 100) begin
      ncyc++;
      tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    startE = 1'b0;
    flushE = 1'b0;
    mfReqD = 1'b0;
    mdReqD = 1'b0;
    opE    = 3'd6;
    srcAE  = '0;
    srcBE  = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hiOut), 64'd0);
    chk("rst_lo", 64'(loOut), 64'd0);
    chk("rst_stall", 64'(stallMD), 64'd0);
    rst_n = 1'b1;
    tick();

    // MULT -3 * 7
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, cyc);
    chk("mult_cycles", 64'(cyc), 64'd33);
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_hi", 64'(hiOut), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(loOut), 64'hFFFF_FFEB);
    tick();
    chk("mult_done_pulse", 64'(done), 64'd0);

    // MULTU max*max, then DIVU 100/7 accepted in the done cycle
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_hi", 64'(hiOut), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(loOut), 64'h0000_0001);
    run_op(3'd3, 32'd100, 32'd7, cyc);
    chk("divu_cycles", 64'(cyc), 64'd33);
    chk("divu_lo", 64'(loOut), 64'd14);
    chk("divu_hi", 64'(hiOut), 64'd2);

    // DIV signed cases
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    chk("div_neg_lo", 64'(loOut), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hiOut), 64'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div_ovf_lo", 64'(loOut), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hiOut), 64'd0);

    // Divide by zero: FIX in cycle 1, done in cycle 2
    run_op(3'd2, 32'h0000_1234, 32'd0, cyc);
    chk("div0_cycles", 64'(cyc), 64'd1);
    chk("div0_done", 64'(done), 64'd1);
    chk("div0_hi", 64'(hiOut), 64'h1234);
    chk("div0_lo", 64'(loOut), 64'hFFFF_FFFF);
    tick();

    // MFHI held in Decode during MULT 5*6
    mdReqD = 1'b1;
    #1;
    chk("idle_no_stall", 64'(stallMD), 64'd0);
    mdReqD = 1'b0;
    mfReqD = 1'b1;
    startE = 1'b1;
    opE    = 3'd0;
    srcAE  = 32'd5;
    srcBE  = 32'd6;
    #1;
    chk("stall_accept", 64'(stallMD), 64'd1);
    tick();
    startE = 1'b0;
    cyc = 0;
    while (stallMD && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("stall_cycles", 64'(cyc), 64'd33);
    chk("stall_rel_done", 64'(done), 64'd1);
    chk("stall_rel_hi", 64'(hiOut), 64'd0);
    chk("stall_rel_lo", 64'(loOut), 64'd30);
    mfReqD = 1'b0;
    tick();

    // startE with flushE: nothing starts
    flushE = 1'b1;
    run_op(3'd0, 32'd9, 32'd9, cyc);
    flushE = 1'b0;
    chk("flush_busy_cycles", 64'(cyc), 64'd0);
    tick();
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_lo", 64'(loOut), 64'd30);

    // MTLO / MTHI
    run_op(3'd5, 32'hA5A5_A5A5, 32'd0, cyc);
    chk("mtlo_busy_cycles", 64'(cyc), 64'd0);
    chk("mtlo_lo", 64'(loOut), 64'hA5A5_A5A5);
    chk("mtlo_hi", 64'(hiOut), 64'd0);
    run_op(3'd4, 32'h0000_005A, 32'd0, cyc);
    chk("mthi_hi", 64'(hiOut), 64'h5A);
    chk("mthi_lo", 64'(loOut), 64'hA5A5_A5A5);

    // Reset mid-RUN at cycle 10
    startE = 1'b1;
    opE    = 3'd1;
    srcAE  = 32'd1000;
    srcBE  = 32'd1000;
    tick();
    startE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hiOut), 64'd0);
    chk("midrst_lo", 64'(loOut), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(3'd3, 32'd9, 32'd3, cyc);
    chk("post_rst_cycles", 64'(cyc), 64'd33);
    chk("post_rst_lo", 64'(loOut), 64'd3);
    chk("post_rst_hi", 64'(hiOut), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
